piece_mover: RTL and testbench
==============================

PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter BOARD_W, default 4, board columns (>=2).
REQ-002 SHALL have parameter BOARD_H, default 8, board rows (>=2); N = BOARD_W*BOARD_H cells, LOC_W = ceil(log2(N)).
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port left / right / rotate / drop  input  1 each  requested action.
REQ-007 SHALL have port curr_board_state  input  N  occupancy including current piece; bit index = row*BOARD_W + col, row 0 = top.
REQ-008 SHALL have port curr_piece_type  input  2  0 dot, 1 domino, 2 L, 3 square.
REQ-009 SHALL have port curr_piece_location  input  LOC_W  cell index of top-left of the piece's 2x2 box.
REQ-010 SHALL have port curr_piece_rotation  input  2  clockwise quarter turns.
REQ-011 SHALL have port new_board_state  output  N  board after move.
REQ-012 SHALL have port new_location  output  LOC_W;  new_rotation  output  2.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse;  busy  output  1  high outside IDLE.
REQ-014 SHALL have port blocked  output  1  action rejected;  landed  output  1  drop rejected.

Function
REQ-015 Box mask bits SHALL be b0 TL, b1 TR, b2 BL, b3 BR. Per rotation 0..3: dot TL,TR,BR,BL; domino TL+TR, TR+BR, BL+BR, TL+BL; L TL+BL+BR, TL+TR+BL, TL+TR+BR, TR+BL+BR; square all four.
REQ-016 FSM SHALL be IDLE -> CAPTURE -> ERASE -> CHECK -> COMMIT -> IDLE; IDLE->CAPTURE on start, all other transitions unconditional.
REQ-017 CAPTURE SHALL register all inputs; input changes after that cycle SHALL NOT affect the operation.
REQ-018 ERASE SHALL clear the current piece cells from the captured board (AND-NOT); cells out of bounds are ignored.
REQ-019 CHECK SHALL select one action by priority rotate > left > right > drop; if left and right are both high, both SHALL be ignored; no action selected -> candidate = current.
REQ-020 Candidates SHALL be: rotate -> rotation+1 mod 4; left -> col-1; right -> col+1; drop -> row+1.
REQ-021 A candidate SHALL be blocked if any set mask cell has col >= BOARD_W, row >= BOARD_H, col < 0, or hits an occupied cell of the erased board; column overflow SHALL NOT wrap to the next row.
REQ-022 COMMIT SHALL OR the mask at the candidate (or original, if blocked) into the erased board and update new_board_state, new_location, new_rotation, blocked, landed together.
REQ-023 landed SHALL be 1 only when drop is the selected action and blocked; otherwise 0.
REQ-024 done SHALL pulse for exactly the cycle after COMMIT; latency start-sampled edge to done = 4 cycles.
REQ-025 Outputs other than done/busy SHALL hold until the next COMMIT.
REQ-026 start while busy SHALL be ignored (not queued); start held high SHALL begin a new operation the cycle after done.
REQ-027 curr_piece_location >= N SHALL yield blocked=1 and board passed through unchanged.

Reset
REQ-028 reset SHALL force IDLE and set new_board_state, new_location, new_rotation, done, busy, blocked, landed to 0 immediately, including mid-operation.
REQ-029 After reset deassertion, the first start SHALL be accepted normally; no partial result SHALL be emitted.

Structure
REQ-030 A shared package SHALL hold piece type codes, the mask table, action priority encoding and FSM state enum.
REQ-031 One sub-module, piece_fit_check (combinational: board, type, rotation, location in -> cell mask N bits, fits flag), SHALL be used by ERASE, CHECK and COMMIT.
REQ-032 Target size SHALL be 120-400 lines of RTL total.

Verification (BOARD_W=4, BOARD_H=8)
REQ-033 Square at loc 0, board 0x00000033, right -> done at +4 cycles, loc 1, board 0x00000066, blocked 0.
REQ-034 Domino rot0 at loc 2, board 0x0000000C, right -> blocked 1, loc 2, board 0x0000000C (no wrap into row 1).
REQ-035 Dot at loc 0 beside fixed cell, board 0x00000003, right -> blocked 1, board 0x00000003.
REQ-036 Square at loc 24, board 0x33000000, drop -> blocked 1, landed 1, board unchanged.
REQ-037 L rot0 at loc 0, board 0x00000031, rotate -> rotation 1, board 0x00000013; left+right+drop together -> drop executes, left/right ignored.
REQ-038 Assert reset during ERASE -> all outputs 0 at once, no done; start pulsed during CHECK -> ignored.

Source files
------------

// File: rtl/piece_mover_pkg.sv
// -----------------------------------------------------------------------------
// piece_mover_pkg
// Shared definitions for the piece mover:
//   - piece type codes (piece_t)
//   - 2x2 box occupancy table per piece type and rotation (box_mask)
//   - action codes and the priority encoder that picks one action
//   - FSM state enumeration
// Box mask bit order: b0 = top-left, b1 = top-right, b2 = bottom-left,
// b3 = bottom-right of the piece's 2x2 bounding box.
// -----------------------------------------------------------------------------
package piece_mover_pkg;

  typedef enum logic [1:0] {
    PIECE_DOT    = 2'd0,
    PIECE_DOMINO = 2'd1,
    PIECE_L      = 2'd2,
    PIECE_SQUARE = 2'd3
  } piece_t;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_ROTATE = 3'd1,
    ACT_LEFT   = 3'd2,
    ACT_RIGHT  = 3'd3,
    ACT_DROP   = 3'd4
  } action_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ERASE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  // Occupied cells of the 2x2 box for a given piece and clockwise rotation.
  function automatic logic [3:0] box_mask(input piece_t i_type, input logic [1:0] i_rot);
    logic [3:0] w_m;
    case ({i_type, i_rot})
      4'b00_00: w_m = 4'b0001;  // dot: TL
      4'b00_01: w_m = 4'b0010;  // dot: TR
      4'b00_10: w_m = 4'b1000;  // dot: BR
      4'b00_11: w_m = 4'b0100;  // dot: BL
      4'b01_00: w_m = 4'b0011;  // domino: TL+TR
      4'b01_01: w_m = 4'b1010;  // domino: TR+BR
      4'b01_10: w_m = 4'b1100;  // domino: BL+BR
      4'b01_11: w_m = 4'b0101;  // domino: TL+BL
      4'b10_00: w_m = 4'b1101;  // L: TL+BL+BR
      4'b10_01: w_m = 4'b0111;  // L: TL+TR+BL
      4'b10_10: w_m = 4'b1011;  // L: TL+TR+BR
      4'b10_11: w_m = 4'b1110;  // L: TR+BL+BR
      4'b11_00: w_m = 4'b1111;  // square
      4'b11_01: w_m = 4'b1111;
      4'b11_10: w_m = 4'b1111;
      4'b11_11: w_m = 4'b1111;
      default:  w_m = 4'b0000;
    endcase
    return w_m;
  endfunction

  // Priority rotate > left > right > drop; left and right together cancel each other.
  function automatic action_t select_action(input logic i_rotate, input logic i_left,
                                            input logic i_right, input logic i_drop);
    action_t w_a;
    if (i_rotate) begin
      w_a = ACT_ROTATE;
    end else if (i_left && !i_right) begin
      w_a = ACT_LEFT;
    end else if (i_right && !i_left) begin
      w_a = ACT_RIGHT;
    end else if (i_drop) begin
      w_a = ACT_DROP;
    end else begin
      w_a = ACT_NONE;
    end
    return w_a;
  endfunction

endpackage

// File: rtl/piece_mover_fit_check.sv
// -----------------------------------------------------------------------------
// piece_fit_check (combinational)
// Places a piece's 2x2 box on the board and reports which cells it covers and
// whether it fits.
//   i_board            board to test against (occupied cells = 1)
//   i_type, i_rot      piece type and clockwise rotation
//   i_loc              cell index of the box's top-left corner
//   i_left/i_right     shift the box one column left/right of i_loc
//   i_down             shift the box one row down from i_loc
//   o_mask             in-bounds cells covered by the piece
//   o_fits             1 when no covered cell is out of bounds or occupied
// Row/column arithmetic is done as signed integers so that a left shift from
// column 0 becomes column -1 (out of bounds) instead of wrapping to the
// previous row, and a right shift past the last column never wraps forward.
// -----------------------------------------------------------------------------
module piece_fit_check
  import piece_mover_pkg::*;
#(
  parameter  int BOARD_W = 4,
  parameter  int BOARD_H = 8,
  localparam int N       = BOARD_W * BOARD_H,
  localparam int LOC_W   = $clog2(N)
) (
  input  logic [N-1:0]     i_board,
  input  piece_t           i_type,
  input  logic [1:0]       i_rot,
  input  logic [LOC_W-1:0] i_loc,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_down,
  output logic [N-1:0]     o_mask,
  output logic             o_fits
);

  logic [3:0] w_box;
  int         w_row;
  int         w_col;
  logic       w_oob;

  // Map the box onto board cells and flag any occupied box cell that falls off the board.
  always_comb begin
    w_box  = box_mask(i_type, i_rot);
    w_row  = (int'(i_loc) / BOARD_W) + int'(i_down);
    w_col  = (int'(i_loc) % BOARD_W) + int'(i_right) - int'(i_left);
    w_oob  = 1'b0;
    o_mask = '0;
    for (int b = 0; b < 4; b++) begin
      w_oob = w_oob | (w_box[b] && ((w_col + (b % 2) < 0) ||
                                    (w_col + (b % 2) >= BOARD_W) ||
                                    (w_row + (b / 2) >= BOARD_H)));
    end
    // A cell is covered only when both its row and column match exactly, so
    // off-board box cells never alias onto a neighbouring row.
    for (int c = 0; c < N; c++) begin
      for (int b = 0; b < 4; b++) begin
        o_mask[c] = o_mask[c] | (w_box[b] && ((c / BOARD_W) == (w_row + (b / 2))) &&
                                             ((c % BOARD_W) == (w_col + (b % 2))));
      end
    end
    o_fits = !w_oob && ((o_mask & i_board) == '0);
  end

endmodule

// File: rtl/piece_mover.sv
// -----------------------------------------------------------------------------
// piece_mover (top)
// Applies one requested action (rotate, left, right, drop) to the current
// piece on the board and produces the resulting board.
//   clk, reset             clock; asynchronous active-high reset
//   start                  begin an operation (sampled only while idle)
//   left/right/rotate/drop requested action
//   curr_board_state       board including the current piece (bit = row*W+col)
//   curr_piece_type/_location/_rotation  current piece description
//   new_board_state/new_location/new_rotation  result of the last operation
//   done                   one-cycle pulse after the result is written
//   busy                   high while an operation is in progress
//   blocked                the action was rejected (piece left where it was)
//   landed                 a drop was rejected
// Sequence: IDLE -> CAPTURE -> ERASE -> CHECK -> COMMIT -> IDLE. A single
// piece_fit_check instance serves ERASE, CHECK and COMMIT through an input mux.
// -----------------------------------------------------------------------------
module piece_mover
  import piece_mover_pkg::*;
#(
  parameter  int BOARD_W = 4,
  parameter  int BOARD_H = 8,
  localparam int N       = BOARD_W * BOARD_H,
  localparam int LOC_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             left,
  input  logic             right,
  input  logic             rotate,
  input  logic             drop,
  input  logic [N-1:0]     curr_board_state,
  input  logic [1:0]       curr_piece_type,
  input  logic [LOC_W-1:0] curr_piece_location,
  input  logic [1:0]       curr_piece_rotation,
  output logic [N-1:0]     new_board_state,
  output logic [LOC_W-1:0] new_location,
  output logic [1:0]       new_rotation,
  output logic             done,
  output logic             busy,
  output logic             blocked,
  output logic             landed
);

  state_t           r_state;
  state_t           w_next;

  // Captured operation
  logic [N-1:0]     r_board;
  piece_t           r_type;
  logic [LOC_W-1:0] r_loc;
  logic [1:0]       r_rot;
  action_t          r_act;

  // Intermediate results
  logic [N-1:0]     r_erased;
  logic             r_blk_pend;

  // Output registers
  logic [N-1:0]     r_new_board;
  logic [LOC_W-1:0] r_new_loc;
  logic [1:0]       r_new_rot;
  logic             r_done;
  logic             r_busy;
  logic             r_blocked;
  logic             r_landed;

  // Per-state strobes
  logic             w_capture;
  logic             w_erase;
  logic             w_check;
  logic             w_commit;
  logic             w_busy_nxt;

  // Candidate placement
  logic [1:0]       w_cand_rot;
  logic             w_cand_left;
  logic             w_cand_right;
  logic             w_cand_down;
  logic [LOC_W-1:0] w_cand_loc;

  // Fit checker interface
  logic [1:0]       w_fc_rot;
  logic             w_fc_left;
  logic             w_fc_right;
  logic             w_fc_down;
  logic [N-1:0]     w_fc_mask;
  logic             w_fc_fits;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: only IDLE waits; every other state advances each cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = start ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: w_next = ST_ERASE;
      ST_ERASE:   w_next = ST_CHECK;
      ST_CHECK:   w_next = ST_COMMIT;
      ST_COMMIT:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: per-state strobes and next busy value.
  always_comb begin
    w_capture  = 1'b0;
    w_erase    = 1'b0;
    w_check    = 1'b0;
    w_commit   = 1'b0;
    w_busy_nxt = (w_next != ST_IDLE);
    case (r_state)
      ST_CAPTURE: w_capture = 1'b1;
      ST_ERASE:   w_erase   = 1'b1;
      ST_CHECK:   w_check   = 1'b1;
      ST_COMMIT:  w_commit  = 1'b1;
      default: begin
        w_capture = 1'b0;
      end
    endcase
  end

  // Candidate rotation, shift and resulting location for the selected action.
  always_comb begin
    w_cand_rot   = (r_act == ACT_ROTATE) ? (r_rot + 2'd1) : r_rot;
    w_cand_left  = (r_act == ACT_LEFT);
    w_cand_right = (r_act == ACT_RIGHT);
    w_cand_down  = (r_act == ACT_DROP);
    case (r_act)
      ACT_LEFT:  w_cand_loc = r_loc - LOC_W'(1);
      ACT_RIGHT: w_cand_loc = r_loc + LOC_W'(1);
      ACT_DROP:  w_cand_loc = r_loc + LOC_W'(BOARD_W);
      default:   w_cand_loc = r_loc;
    endcase
  end

  // Fit checker input mux: CHECK tests the candidate, COMMIT re-places the
  // candidate (or the original piece when blocked), ERASE uses the original.
  always_comb begin
    w_fc_rot   = r_rot;
    w_fc_left  = 1'b0;
    w_fc_right = 1'b0;
    w_fc_down  = 1'b0;
    case (r_state)
      ST_CHECK: begin
        w_fc_rot   = w_cand_rot;
        w_fc_left  = w_cand_left;
        w_fc_right = w_cand_right;
        w_fc_down  = w_cand_down;
      end
      ST_COMMIT: begin
        if (!r_blk_pend) begin
          w_fc_rot   = w_cand_rot;
          w_fc_left  = w_cand_left;
          w_fc_right = w_cand_right;
          w_fc_down  = w_cand_down;
        end else begin
          w_fc_rot   = r_rot;
        end
      end
      default: begin
        w_fc_rot = r_rot;
      end
    endcase
  end

  piece_fit_check #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_fit (
    .i_board (r_erased),
    .i_type  (r_type),
    .i_rot   (w_fc_rot),
    .i_loc   (r_loc),
    .i_left  (w_fc_left),
    .i_right (w_fc_right),
    .i_down  (w_fc_down),
    .o_mask  (w_fc_mask),
    .o_fits  (w_fc_fits)
  );

  // Capture the request, decoding the action once so later input changes are irrelevant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board <= '0;
      r_type  <= PIECE_DOT;
      r_loc   <= '0;
      r_rot   <= 2'd0;
      r_act   <= ACT_NONE;
    end else if (w_capture) begin
      r_board <= curr_board_state;
      r_type  <= piece_t'(curr_piece_type);
      r_loc   <= curr_piece_location;
      r_rot   <= curr_piece_rotation;
      r_act   <= select_action(rotate, left, right, drop);
    end
  end

  // Erase the current piece from the captured board, then record whether the candidate fits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_erased   <= '0;
      r_blk_pend <= 1'b0;
    end else if (w_erase) begin
      r_erased   <= r_board & ~w_fc_mask;
    end else if (w_check) begin
      r_blk_pend <= !w_fc_fits;
    end
  end

  // Result registers: written together in COMMIT and held until the next COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_new_board <= '0;
      r_new_loc   <= '0;
      r_new_rot   <= 2'd0;
      r_blocked   <= 1'b0;
      r_landed    <= 1'b0;
    end else if (w_commit) begin
      r_new_board <= r_erased | w_fc_mask;
      r_new_loc   <= r_blk_pend ? r_loc : w_cand_loc;
      r_new_rot   <= r_blk_pend ? r_rot : w_cand_rot;
      r_blocked   <= r_blk_pend;
      r_landed    <= r_blk_pend && (r_act == ACT_DROP);
    end
  end

  // Status registers: busy follows the next state, done marks the cycle after COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_busy <= w_busy_nxt;
    end
  end

  assign new_board_state = r_new_board;
  assign new_location    = r_new_loc;
  assign new_rotation    = r_new_rot;
  assign done            = r_done;
  assign busy            = r_busy;
  assign blocked         = r_blocked;
  assign landed          = r_landed;

endmodule

// File: tb/tb_piece_mover.sv
// -----------------------------------------------------------------------------
// tb_piece_mover
// Directed tests for piece_mover on a 4x8 board. A behavioural model describes
// pieces as cells on a clockwise ring around the 2x2 box and predicts each
// operation's result and timing; a compare process checks every cycle, and the
// directed tests additionally pin hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_piece_mover;

  localparam int W = 4;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, left, right, rotate, drop;
  logic [31:0] board;
  logic [1:0]  ptype;
  logic [4:0]  ploc;
  logic [1:0]  prot;
  logic [31:0] nb;
  logic [4:0]  nloc;
  logic [1:0]  nrot;
  logic        done, busy, blocked, landed;

  int checks   = 0;
  int failures = 0;

  piece_mover #(.BOARD_W(4), .BOARD_H(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .left                (left),
    .right               (right),
    .rotate              (rotate),
    .drop                (drop),
    .curr_board_state    (board),
    .curr_piece_type     (ptype),
    .curr_piece_location (ploc),
    .curr_piece_rotation (prot),
    .new_board_state     (nb),
    .new_location        (nloc),
    .new_rotation        (nrot),
    .done                (done),
    .busy                (busy),
    .blocked             (blocked),
    .landed              (landed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Ring position of a box cell, clockwise from top-left.
  function automatic int ring(input int dr, input int dc);
    if (dr == 0) return (dc == 0) ? 0 : 1;
    return (dc == 1) ? 2 : 3;
  endfunction

  // Rotation moves a piece one step clockwise around the ring.
  function automatic bit in_shape(input int t, input int rot, input int dr, input int dc);
    int p;
    p = ring(dr, dc);
    case (t)
      0:       return p == rot;
      1:       return (p == rot) || (p == ((rot + 1) % 4));
      2:       return p != ((rot + 1) % 4);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model(input logic [31:0] b, input int t, input int loc, input int rot,
                       input bit l, input bit r, input bit ro, input bit d,
                       output logic [31:0] onb, output int oloc, output int orot,
                       output bit oblk, output bit olnd);
    int r0, c0, cr, cc, crot, act;
    logic [31:0] e;
    bit ok;
    r0 = loc / W;
    c0 = loc % W;
    e  = b;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (in_shape(t, rot, dr, dc) && (c0 + dc < W) && (r0 + dr < H))
          e[(r0 + dr) * W + c0 + dc] = 1'b0;
    if (ro)               act = 1;
    else if (l && !r)     act = 2;
    else if (r && !l)     act = 3;
    else if (d)           act = 4;
    else                  act = 0;
    cr = r0; cc = c0; crot = rot;
    case (act)
      1: crot = (rot + 1) % 4;
      2: cc = c0 - 1;
      3: cc = c0 + 1;
      4: cr = r0 + 1;
      default: ;
    endcase
    ok = 1'b1;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (in_shape(t, crot, dr, dc)) begin
          if ((cc + dc < 0) || (cc + dc >= W) || (cr + dr >= H)) ok = 1'b0;
          else if (e[(cr + dr) * W + cc + dc]) ok = 1'b0;
        end
    if (!ok) begin
      cr = r0; cc = c0; crot = rot;
    end
    onb = e;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (in_shape(t, crot, dr, dc) && (cc + dc >= 0) && (cc + dc < W) && (cr + dr < H))
          onb[(cr + dr) * W + cc + dc] = 1'b1;
    oloc = ok ? (cr * W + cc) : loc;
    orot = crot;
    oblk = !ok;
    olnd = !ok && (act == 4);
  endtask

  // Model state: operation phase (0 idle, 1 capture .. 4 commit) and expected outputs.
  int          m_phase  = 0;
  bit          m_done   = 1'b0;
  logic [31:0] exp_board = 32'd0, pend_board = 32'd0;
  int          exp_loc = 0, exp_rot = 0, pend_loc = 0, pend_rot = 0;
  bit          exp_blk = 1'b0, exp_lnd = 1'b0, pend_blk = 1'b0, pend_lnd = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_done = 1'b0;
      exp_board = 32'd0; exp_loc = 0; exp_rot = 0; exp_blk = 1'b0; exp_lnd = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (start) m_phase = 1;
      end else if (m_phase == 1) begin
        model(board, int'(ptype), int'(ploc), int'(prot), left, right, rotate, drop,
              pend_board, pend_loc, pend_rot, pend_blk, pend_lnd);
        m_phase = 2;
      end else if (m_phase == 4) begin
        m_phase = 0; m_done = 1'b1;
        exp_board = pend_board; exp_loc = pend_loc; exp_rot = pend_rot;
        exp_blk = pend_blk; exp_lnd = pend_lnd;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_done",    64'(done),    64'(m_done));
    chk("cyc_busy",    64'(busy),    64'(m_phase != 0));
    chk("cyc_board",   64'(nb),      64'(exp_board));
    chk("cyc_loc",     64'(nloc),    64'(exp_loc));
    chk("cyc_rot",     64'(nrot),    64'(exp_rot));
    chk("cyc_blocked", 64'(blocked), 64'(exp_blk));
    chk("cyc_landed",  64'(landed),  64'(exp_lnd));
  end

  task automatic drive(input logic [31:0] b, input int t, input int loc, input int rot,
                       input bit l, input bit r, input bit ro, input bit d);
    board = b; ptype = t[1:0]; ploc = loc[4:0]; prot = rot[1:0];
    left = l; right = r; rotate = ro; drop = d;
  endtask

  task automatic scramble();
    board = $urandom; ptype = 2'($urandom); ploc = 5'($urandom); prot = 2'($urandom);
    left = 1'($urandom); right = 1'($urandom); rotate = 1'($urandom); drop = 1'($urandom);
  endtask

  task automatic check_lits(input string nm, input logic [31:0] eb, input int el, input int er,
                            input bit eblk, input bit elnd);
    chk({nm, "_board"},   64'(nb),      64'(eb));
    chk({nm, "_loc"},     64'(nloc),    64'(el));
    chk({nm, "_rot"},     64'(nrot),    64'(er));
    chk({nm, "_blocked"}, 64'(blocked), 64'(eblk));
    chk({nm, "_landed"},  64'(landed),  64'(elnd));
  endtask

  // One operation: pulse start, scramble inputs after capture, optionally poke
  // start during CHECK, then check latency and the literal result.
  task automatic run_op(input string nm, input logic [31:0] b, input int t, input int loc,
                        input int rot, input bit l, input bit r, input bit ro, input bit d,
                        input logic [31:0] eb, input int el, input int er,
                        input bit eblk, input bit elnd, input bit poke);
    int cyc;
    drive(b, t, loc, rot, l, r, ro, d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((cyc < 20) && !done) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) scramble();
      if (poke && (cyc == 2)) start = 1'b1;
      if (poke && (cyc == 3)) start = 1'b0;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(4));
    check_lits(nm, eb, el, er, eblk, elnd);
    @(posedge clk); #1;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_poke_ignored"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0;
    drive(32'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_lits("reset", 32'd0, 0, 0, 1'b0, 1'b0);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("sq_right",   32'h0000_0033, 3, 0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0066, 1,  0, 1'b0, 1'b0, 1'b0);
    run_op("dom_nowrap", 32'h0000_000C, 1, 2,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 2,  0, 1'b1, 1'b0, 1'b0);
    run_op("dot_side",   32'h0000_0003, 0, 0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0003, 0,  0, 1'b1, 1'b0, 1'b0);
    run_op("sq_land",    32'h3300_0000, 3, 24, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3300_0000, 24, 0, 1'b1, 1'b1, 1'b0);
    run_op("l_rotate",   32'h0000_0031, 2, 0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 0,  1, 1'b0, 1'b0, 1'b0);
    run_op("l_lrd",      32'h0000_0031, 2, 0,  0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0310, 4,  0, 1'b0, 1'b0, 1'b0);
    run_op("dot_left0",  32'h0000_0001, 0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 0,  0, 1'b1, 1'b0, 1'b0);
    run_op("dom_rotblk", 32'h0000_0023, 1, 0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0023, 0,  0, 1'b1, 1'b0, 1'b0);
    run_op("sq_none",    32'h0000_CC00, 3, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_CC00, 10, 0, 1'b0, 1'b0, 1'b0);
    run_op("dot_drop",   32'h0000_0020, 0, 5,  0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 9,  0, 1'b0, 1'b0, 1'b1);

    // start held high: a second operation begins right after done.
    drive(32'h0000_0020, 0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while ((cyc < 20) && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_latency", 64'(cyc), 64'(4));
    @(posedge clk); #1;
    chk("held_restart_busy", 64'(busy), 64'(1));
    start = 1'b0;
    cyc = 0;
    while ((cyc < 20) && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_second_latency", 64'(cyc), 64'(4));
    check_lits("held_second", 32'h0000_0200, 9, 0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset asserted during ERASE clears everything at once and emits no done.
    drive(32'h0000_0033, 3, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_lits("midrst", 32'd0, 0, 0, 1'b0, 1'b0);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done), 64'(0));
    check_lits("midrst_hold", 32'd0, 0, 0, 1'b0, 1'b0);

    // First operation after reset is accepted normally.
    run_op("post_rst",   32'h0000_0033, 3, 0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0066, 1,  0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
